leaf_stream_packetizer: RTL and testbench
=========================================

Name: leaf_stream_packetizer

Overview:
- Transmit-side packetizer for a leaf shell. It takes up to NUM_OUT_PORTS user output streams (32-bit payload, vld/ack) and builds 49-bit BFT packets addressed to the configured destination leaf/port.
- Flow control is credit-based against the receiver's BRAM freespace. Ports are arbitrated round-robin onto a single registered BFT output.
- Sits between the user kernel's output streams and the leaf's interface2bft path, in the leaf clock domain.

Parameters:
- PACKET_BITS, 49: BFT packet width.
- PAYLOAD_BITS, 32: user payload width.
- NUM_LEAF_BITS, 5: destination leaf field width.
- NUM_PORT_BITS, 4: destination port field width.
- NUM_ADDR_BITS, 7: receiver BRAM address width.
- NUM_OUT_PORTS, 4: number of user output streams.
- CREDIT_INIT, 128: initial and maximum credits per port (2^NUM_ADDR_BITS).

Ports:
- clk  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- cfg_wr  in  1  destination-table write strobe.
- cfg_port  in  NUM_PORT_BITS  local output port being configured.
- cfg_dst_leaf  in  NUM_LEAF_BITS  destination leaf.
- cfg_dst_port  in  NUM_PORT_BITS  destination port.
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  flat payloads; port i is at bits [i*32 +: 32].
- vld_user2interface  in  NUM_OUT_PORTS  per-port valid.
- ack_interface2user  out  NUM_OUT_PORTS  per-port accept.
- cred_vld  in  1  credit-return strobe.
- cred_port  in  NUM_PORT_BITS  port receiving credits.
- cred_inc  in  NUM_ADDR_BITS+1  credits returned (0..CREDIT_INIT).
- dout_leaf_interface2bft  out  PACKET_BITS  packet; [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
- dout_ready  in  1  BFT accepts the current packet.
- resend  in  1  freeze transmission.
- err_credit_ovf  out  1  sticky credit-overflow flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - dout=0, ack=0, err_credit_ovf=0.
  - All ports unconfigured, credits=CREDIT_INIT, addr counters=0, round-robin pointer=0.
- Config:
  - cfg_wr with cfg_port<NUM_OUT_PORTS writes the destination, marks the port configured, resets its addr counter to 0 and its credits to CREDIT_INIT.
  - cfg_port>=NUM_OUT_PORTS is ignored.
  - A config write overrides any same-cycle credit return on that port.
- Eligibility: port i is eligible when vld[i] && configured[i] && credit[i]!=0.
- Output slot:
  - The slot is free when dout[48]==0, or dout[48]==1 && dout_ready==1.
  - While dout[48]==1 && !dout_ready, dout holds stable.
- Grant:
  - When the slot is free, resend==0 and any port is eligible, grant the first eligible port searching from rr_ptr upward with wrap.
  - ack_interface2user[g]=1 combinationally in that cycle; all other acks are 0. At most one ack per cycle.
  - Transfer occurs on vld&ack.
- On the grant edge:
  - dout <= {1, leaf[g], port[g], addr[g], payload[g]}.
  - addr[g] increments modulo 2^NUM_ADDR_BITS (127 wraps to 0).
  - credit[g] decrements.
  - rr_ptr <= g+1 mod NUM_OUT_PORTS.
- Latency: one cycle from accepted vld&ack to packet on dout. Throughput is one packet per cycle when dout_ready is held high.
- Slot free with no grant: dout[48] <= 0; other fields are don't-care, driven 0.
- Credits:
  - cred_vld adds cred_inc to credit[cred_port]; out-of-range ports are ignored.
  - Same-cycle grant and return on one port: credit = credit - 1 + cred_inc.
  - A result above CREDIT_INIT saturates at CREDIT_INIT and sets err_credit_ovf, which stays set until reset.
  - A port at credit 0 is never acked, even if vld is high.
- Resend:
  - While resend==1: dout port reads all zeros, no grants, acks are 0.
  - The internally held packet is retained and reappears unchanged after resend drops.
  - A held packet is not considered accepted while resend==1, regardless of dout_ready.
- Reset mid-packet: the held packet is discarded, with no partial state.

Test Plan:
- Configure port0→leaf 3/port 2; push 0xDEADBEEF with dout_ready=1 → next cycle dout = {1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}; a second word carries addr 1.
- All 4 ports valid and configured, dout_ready=1 → grants 0,1,2,3,0… in successive cycles, exactly one ack per cycle.
- Port1 credit drained by 128 sends with no returns → ack[1] stays 0. Then cred_vld, port1, inc=1 → exactly one more packet, whose addr field wraps to 0 (the 129th packet).
- Hold dout_ready=0 with a valid packet for 5 cycles → dout is stable and no acks; release → the next packet follows in the next cycle.
- Assert resend for 3 cycles with a packet held → dout=0 and no acks. Deassert → the same packet reappears, then is accepted.
- cred_inc=1 returned on a port at CREDIT_INIT → credit stays 128, err_credit_ovf=1 and remains 1 until reset is asserted low.

Source files
------------

// File: rtl/leaf_stream_packetizer.sv
// Transmit-side packetizer: round-robin arbitration of user output streams onto a
// single registered BFT packet slot, with per-port credit flow control.
module leaf_stream_packetizer #(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS = 4,
  parameter int CREDIT_INIT   = 128
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  cfg_wr,
  input  logic [NUM_PORT_BITS-1:0]              cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dst_port,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  input  logic                                  cred_vld,
  input  logic [NUM_PORT_BITS-1:0]              cred_port,
  input  logic [NUM_ADDR_BITS:0]                cred_inc,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  dout_ready,
  input  logic                                  resend,
  output logic                                  err_credit_ovf
);

  localparam int PTR_BITS  = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam int CRED_BITS = NUM_ADDR_BITS + 1;
  localparam int SUM_BITS  = CRED_BITS + 1;

  logic [NUM_LEAF_BITS-1:0] dst_leaf   [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0] dst_port   [NUM_OUT_PORTS];
  logic [NUM_ADDR_BITS-1:0] addr_q     [NUM_OUT_PORTS];
  logic [CRED_BITS-1:0]     credit_q   [NUM_OUT_PORTS];
  logic [CRED_BITS-1:0]     credit_nxt [NUM_OUT_PORTS];

  logic [NUM_OUT_PORTS-1:0] configured_q;
  logic [NUM_OUT_PORTS-1:0] eligible;
  logic [NUM_OUT_PORTS-1:0] cfg_sel;
  logic [NUM_OUT_PORTS-1:0] gnt_sel;
  logic [NUM_OUT_PORTS-1:0] ovf_hit;
  logic [PTR_BITS-1:0]      rr_ptr;
  logic [PTR_BITS-1:0]      rr_nxt;
  logic [PTR_BITS-1:0]      gnt_idx;
  logic                     gnt_vld;
  logic                     slot_free;
  logic                     err_q;
  logic [PACKET_BITS-1:0]   pkt_q;
  logic [PACKET_BITS-1:0]   pkt_nxt;
  logic [SUM_BITS-1:0]      sum;
  int unsigned              cand;

  // Resend freezes the slot: the held packet is neither accepted nor replaced.
  assign slot_free = !resend && (!pkt_q[PACKET_BITS-1] || dout_ready);

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      eligible[i] = vld_user2interface[i] && configured_q[i] && (credit_q[i] != '0);
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 0; k < NUM_OUT_PORTS; k++) begin
      cand = (32'(rr_ptr) + k) % NUM_OUT_PORTS;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        if (slot_free && !gnt_vld && eligible[i] && (cand == i)) begin
          gnt_vld = 1'b1;
          gnt_idx = PTR_BITS'(i);
        end
      end
    end
  end

  always_comb begin
    gnt_sel = '0;
    pkt_nxt = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      gnt_sel[i] = gnt_vld && (gnt_idx == PTR_BITS'(i));
      if (gnt_sel[i]) begin
        pkt_nxt = {1'b1, dst_leaf[i], dst_port[i], addr_q[i],
                   din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      end
    end
  end

  assign rr_nxt = (gnt_idx == PTR_BITS'(NUM_OUT_PORTS - 1)) ? '0 : gnt_idx + 1'b1;

  // Credit update: grant and return combine first, then saturate; config wins outright.
  always_comb begin
    sum     = '0;
    cfg_sel = '0;
    ovf_hit = '0;
    for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
      cfg_sel[i] = cfg_wr && (cfg_port == NUM_PORT_BITS'(i));
      sum = {1'b0, credit_q[i]};
      if (gnt_sel[i]) begin
        sum = sum - 1'b1;
      end
      if (cred_vld && (cred_port == NUM_PORT_BITS'(i))) begin
        sum = sum + SUM_BITS'(cred_inc);
      end
      if (cfg_sel[i]) begin
        credit_nxt[i] = CRED_BITS'(CREDIT_INIT);
      end else if (sum > SUM_BITS'(CREDIT_INIT)) begin
        credit_nxt[i] = CRED_BITS'(CREDIT_INIT);
        ovf_hit[i]    = 1'b1;
      end else begin
        credit_nxt[i] = sum[CRED_BITS-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_q        <= '0;
      rr_ptr       <= '0;
      err_q        <= 1'b0;
      configured_q <= '0;
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        dst_leaf[i] <= '0;
        dst_port[i] <= '0;
        addr_q[i]   <= '0;
        credit_q[i] <= CRED_BITS'(CREDIT_INIT);
      end
    end else begin
      if (slot_free) begin
        pkt_q <= pkt_nxt;
      end
      if (gnt_vld) begin
        rr_ptr <= rr_nxt;
      end
      if (|ovf_hit) begin
        err_q <= 1'b1;
      end
      for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
        credit_q[i] <= credit_nxt[i];
        if (cfg_sel[i]) begin
          dst_leaf[i]     <= cfg_dst_leaf;
          dst_port[i]     <= cfg_dst_port;
          configured_q[i] <= 1'b1;
          addr_q[i]       <= '0;
        end else if (gnt_sel[i]) begin
          addr_q[i] <= addr_q[i] + 1'b1;
        end
      end
    end
  end

  assign ack_interface2user      = gnt_sel;
  assign dout_leaf_interface2bft = resend ? '0 : pkt_q;
  assign err_credit_ovf          = err_q;

endmodule

// File: tb/tb_leaf_stream_packetizer.sv
// Self-checking bench for leaf_stream_packetizer: directed scenarios plus randomized
// traffic, all compared against a cycle-level transaction model.
module tb_leaf_stream_packetizer;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_wr;
  logic [3:0]    cfg_port;
  logic [4:0]    cfg_dst_leaf;
  logic [3:0]    cfg_dst_port;
  logic [127:0]  din;
  logic [N-1:0]  vld;
  logic [N-1:0]  ack;
  logic          cred_vld;
  logic [3:0]    cred_port;
  logic [7:0]    cred_inc;
  logic [48:0]   dout;
  logic          dout_ready;
  logic          resend;
  logic          err;

  leaf_stream_packetizer #(
    .PACKET_BITS   (49),
    .PAYLOAD_BITS  (32),
    .NUM_LEAF_BITS (5),
    .NUM_PORT_BITS (4),
    .NUM_ADDR_BITS (7),
    .NUM_OUT_PORTS (N),
    .CREDIT_INIT   (128)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .cfg_wr                  (cfg_wr),
    .cfg_port                (cfg_port),
    .cfg_dst_leaf            (cfg_dst_leaf),
    .cfg_dst_port            (cfg_dst_port),
    .din_leaf_user2interface (din),
    .vld_user2interface      (vld),
    .ack_interface2user      (ack),
    .cred_vld                (cred_vld),
    .cred_port               (cred_port),
    .cred_inc                (cred_inc),
    .dout_leaf_interface2bft (dout),
    .dout_ready              (dout_ready),
    .resend                  (resend),
    .err_credit_ovf          (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model of the packetizer state.
  bit          m_cfg  [N];
  int          m_leaf [N];
  int          m_dport[N];
  int          m_addr [N];
  int          m_cred [N];
  int          m_rr;
  bit          m_err;
  logic [48:0] m_pkt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      m_cfg[p] = 1'b0; m_leaf[p] = 0; m_dport[p] = 0; m_addr[p] = 0; m_cred[p] = 128;
    end
    m_rr = 0; m_err = 1'b0; m_pkt = '0;
  endtask

  task automatic idle_inputs();
    cfg_wr = 1'b0; cfg_port = '0; cfg_dst_leaf = '0; cfg_dst_port = '0;
    din = '0; vld = '0; cred_vld = 1'b0; cred_port = '0; cred_inc = '0;
    dout_ready = 1'b1; resend = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven: checks outputs, advances model one clock.
  task automatic step();
    int g;
    int c;
    bit free;
    logic [N-1:0] eack;
    #1;
    free = !resend && (!m_pkt[48] || dout_ready);
    g = -1;
    if (free) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_rr + k) % N;
        if (g < 0 && vld[p] && m_cfg[p] && m_cred[p] != 0) g = p;
      end
    end
    eack = '0;
    if (g >= 0) eack[g] = 1'b1;
    check("ack", 64'(ack), 64'(eack));
    check("dout", 64'(dout), resend ? 64'd0 : 64'(m_pkt));
    check("err", 64'(err), 64'(m_err));
    if (g >= 0) begin
      m_pkt = {1'b1, 5'(m_leaf[g]), 4'(m_dport[g]), 7'(m_addr[g]), din[g*32 +: 32]};
      m_addr[g] = (m_addr[g] + 1) % 128;
      m_rr = (g + 1) % N;
    end else if (free) begin
      m_pkt = '0;
    end
    for (int p = 0; p < N; p++) begin
      c = m_cred[p];
      if (g == p) c = c - 1;
      if (cred_vld && int'(cred_port) == p) c = c + int'(cred_inc);
      if (cfg_wr && int'(cfg_port) == p) begin
        m_cfg[p] = 1'b1; m_leaf[p] = int'(cfg_dst_leaf); m_dport[p] = int'(cfg_dst_port);
        m_addr[p] = 0; m_cred[p] = 128;
      end else begin
        if (c > 128) begin c = 128; m_err = 1'b1; end
        m_cred[p] = c;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic configure(input int port, input int leaf, input int dport);
    cfg_wr = 1'b1; cfg_port = 4'(port); cfg_dst_leaf = 5'(leaf); cfg_dst_port = 4'(dport);
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic random_inputs();
    din        = {$urandom, $urandom, $urandom, $urandom};
    vld        = 4'($urandom);
    dout_ready = ($urandom % 4) != 0;
    resend     = ($urandom % 12) == 0;
    cred_vld   = ($urandom % 3) == 0;
    cred_port  = 4'($urandom % 5);
    cred_inc   = 8'($urandom % 3);
    cfg_wr     = ($urandom % 40) == 0;
    cfg_port   = 4'($urandom % 6);
    cfg_dst_leaf = 5'($urandom);
    cfg_dst_port = 4'($urandom);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    @(negedge clk);
    vld = '1;
    #1;
    check("rst_dout", 64'(dout), 64'd0);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    step();

    // First packets on port 0 toward leaf 3 / port 2.
    configure(0, 3, 2);
    din[31:0] = 32'hDEADBEEF; vld = 4'b0001;
    step();
    #1 check("pkt_first", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
    din[31:0] = 32'h12345678;
    step();
    #1 check("pkt_second", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd1, 32'h12345678}));
    vld = '0;
    step();

    // Round-robin across all configured ports.
    configure(1, 7, 1);
    configure(2, 17, 9);
    configure(3, 31, 15);
    vld = '1;
    for (int k = 0; k < 9; k++) begin
      din = {$urandom, $urandom, $urandom, $urandom};
      step();
    end
    vld = '0;
    step();

    // Drain port 1 credits, then one return gives exactly one more packet with wrapped addr.
    configure(1, 5, 6);
    vld = 4'b0010;
    for (int k = 0; k < 132; k++) begin
      din[63:32] = $urandom;
      step();
    end
    cred_vld = 1'b1; cred_port = 4'd1; cred_inc = 8'd1;
    step();
    cred_vld = 1'b0; cred_inc = '0;
    step();
    #1 check("wrap_addr", 64'(dout[38:32]), 64'd0);
    check("wrap_vld", 64'(dout[48]), 64'd1);
    for (int k = 0; k < 3; k++) step();
    vld = '0;
    step();

    // Backpressure: packet held stable, no acks.
    configure(2, 9, 3);
    vld = 4'b0100; dout_ready = 1'b1;
    step();
    dout_ready = 1'b0; vld = 4'b0101;
    for (int k = 0; k < 5; k++) step();
    dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();

    // Resend freezes the held packet even with dout_ready high.
    dout_ready = 1'b0;
    step();
    resend = 1'b1; dout_ready = 1'b1;
    for (int k = 0; k < 3; k++) step();
    resend = 1'b0;
    for (int k = 0; k < 3; k++) step();
    vld = '0;
    step();

    // Credit return on a full port saturates and sets the sticky flag.
    configure(3, 2, 2);
    cred_vld = 1'b1; cred_port = 4'd3; cred_inc = 8'd1;
    step();
    cred_vld = 1'b0; cred_inc = '0;
    for (int k = 0; k < 4; k++) step();
    #1 check("ovf_sticky", 64'(err), 64'd1);

    // Randomized traffic, with an asynchronous reset mid-run.
    for (int k = 0; k < 1500; k++) begin
      random_inputs();
      step();
    end
    #2 reset = 1'b0;
    #1;
    check("mid_rst_dout", 64'(dout), 64'd0);
    check("mid_rst_ack", 64'(ack), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    step();
    for (int p = 0; p < N; p++) configure(p, p + 4, p + 1);
    for (int k = 0; k < 1500; k++) begin
      random_inputs();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
